// File: rtl/serie_paralelo_rx.sv
// ---------------------------------------------------------------------------
// serie_paralelo_rx : per-lane serial-to-parallel receiver with COM byte lock
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serie_paralelo_rx #(
  parameter logic [7:0] COM       = 8'hBC,
  parameter int         COM_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] COM_CNT = 4'(COM_COUNT);

  logic [1:0] state;
  logic [7:0] sr;
  logic [2:0] bc;
  logic [3:0] cnt;

  logic [7:0] word;
  logic [3:0] cnt_inc;
  logic       boundary;
  logic       is_com;

  // word is the byte that completes on the current edge
  assign word     = {sr[6:0], data_in};
  assign cnt_inc  = cnt + 4'd1;
  assign boundary = (bc == 3'd7);
  assign is_com   = (word == COM);

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state     <= SEARCH;
      sr        <= 8'h00;
      bc        <= 3'd0;
      cnt       <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr <= word;
      bc <= bc + 3'd1;
      case (state)
        SEARCH: begin
          // sliding match at every bit offset; a hit defines the byte phase
          if (is_com) begin
            bc  <= 3'd0;
            cnt <= 4'd1;
            if (COM_CNT == 4'd1) begin
              state  <= LOCKED;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (is_com) begin
              cnt <= cnt_inc;
              if (cnt_inc == COM_CNT) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              state <= SEARCH;
              cnt   <= 4'd0;
            end
          end
        end
        LOCKED: begin
          // COM bytes are idle fill: drop valid but keep the last data byte
          if (boundary) begin
            if (is_com) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= word;
              valid_out <= 1'b1;
            end
          end
        end
        default: begin
          state <= SEARCH;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
